ddr4_dm_multilane_tx_ctrl: RTL and testbench

Parametrised fabric-side controller for N DDR4 data-mask lanes. It drives each lane IOD's TX_DATA, OE_DATA and ODT_EN, with programmable preamble and postamble and seamless back-to-back bursts. It also sequences the per-lane TX delay line (load, step, out-of-range) for write leveling. It sits between the DDR4 write scheduler and the per-lane DM IOD wrappers, all on FAB_CLK.

---
 rtl/ddr4_dm_multilane_tx_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ddr4_dm_multilane_tx_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_dm_multilane_tx_ctrl.sv
// Fabric-side DDR4 DM multi-lane TX controller: write-burst data/OE/ODT shaping
// plus a write-leveling delay-line sequencer with per-lane tap tracking.
module ddr4_dm_multilane_tx_ctrl #(
   parameter int LANES      = 2,
   parameter int PRE_CYC    = 1,
   parameter int POST_CYC   = 1,
   parameter int ODT_HOLD   = 2,
   parameter int SETTLE_CYC = 4,
   parameter int TAP_W      = 8
) (
   input  logic                   FAB_CLK,
   input  logic                   TX_SYNC_RST,
   input  logic                   WR_EN,
   input  logic [LANES*8-1:0]     WR_DM_N,
   output logic [LANES*8-1:0]     TX_DATA,
   output logic [LANES*4-1:0]     OE_DATA,
   output logic [LANES-1:0]       ODT_EN,
   input  logic                   DL_REQ,
   input  logic [3:0]             DL_LANE,
   input  logic                   DL_LOAD_CMD,
   input  logic                   DL_DIR,
   input  logic [TAP_W-1:0]       DL_STEPS,
   output logic                   DL_BUSY,
   output logic                   DL_DONE,
   output logic                   DL_ERR,
   output logic [LANES*TAP_W-1:0] TAP_CNT,
   output logic [LANES-1:0]       DELAY_LINE_MOVE,
   output logic [LANES-1:0]       DELAY_LINE_DIRECTION,
   output logic [LANES-1:0]       DELAY_LINE_LOAD,
   input  logic [LANES-1:0]       DELAY_LINE_OUT_OF_RANGE
);

   localparam int D        = PRE_CYC + 1;
   localparam int OE_LEN   = D + POST_CYC;
   localparam int HIST_LEN = OE_LEN + ODT_HOLD;
   localparam int LW       = (LANES > 1) ? $clog2(LANES) : 1;

   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);
   localparam logic [TAP_W-1:0] TAP_MAX     = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MOVE,
      S_SETTLE,
      S_DONE
   } dl_state_t;

   // ------------------------------------------------------------------
   // Write path: bit k of wr_hist is WR_EN from k+1 cycles ago, so the OE
   // window and the ODT hold are plain ORs over the history, and
   // back-to-back bursts merge without any extra bookkeeping.
   // ------------------------------------------------------------------
   logic [HIST_LEN-1:0]        wr_hist;
   logic [D-1:0][LANES*8-1:0]  dm_pipe;
   logic                       oe;
   logic                       odt;

   always_ff @(posedge FAB_CLK) begin
      if (TX_SYNC_RST) begin
         wr_hist <= '0;
         dm_pipe <= '1;
      end else begin
         wr_hist    <= {wr_hist[HIST_LEN-2:0], WR_EN};
         dm_pipe[0] <= WR_EN ? WR_DM_N : '1;
         for (int i = 1; i < D; i++) begin
            dm_pipe[i] <= dm_pipe[i-1];
         end
      end
   end

   assign oe      = |wr_hist[OE_LEN-1:0];
   assign odt     = |wr_hist;
   assign TX_DATA = dm_pipe[D-1];
   assign OE_DATA = {(LANES*4){oe}};
   assign ODT_EN  = {LANES{odt}};

   // ------------------------------------------------------------------
   // Delay-line sequencer
   // ------------------------------------------------------------------
   dl_state_t        dl_state;
   logic [LW-1:0]    lane_q;
   logic             dir_q;
   logic             load_q;
   logic [TAP_W-1:0] steps_rem;
   logic [3:0]       settle_cnt;
   logic [TAP_W-1:0] tap_q [LANES];

   always_ff @(posedge FAB_CLK) begin
      if (TX_SYNC_RST) begin
         dl_state             <= S_IDLE;
         lane_q               <= '0;
         dir_q                <= 1'b0;
         load_q               <= 1'b0;
         steps_rem            <= '0;
         settle_cnt           <= '0;
         DL_BUSY              <= 1'b0;
         DL_DONE              <= 1'b0;
         DL_ERR               <= 1'b0;
         DELAY_LINE_MOVE      <= '0;
         DELAY_LINE_LOAD      <= '0;
         DELAY_LINE_DIRECTION <= '0;
         // NOTE: the tap array is architectural state visible on TAP_CNT, so
         // every entry is reset explicitly rather than left as uninitialised RAM.
         for (int i = 0; i < LANES; i++) begin
            tap_q[i] <= '0;
         end
      end else begin
         DL_DONE         <= 1'b0;
         DELAY_LINE_MOVE <= '0;
         DELAY_LINE_LOAD <= '0;
         case (dl_state)
            S_IDLE: begin
               if (DL_REQ) begin
                  if (int'(DL_LANE) < LANES) begin
                     lane_q    <= DL_LANE[LW-1:0];
                     dir_q     <= DL_DIR;
                     load_q    <= DL_LOAD_CMD;
                     steps_rem <= DL_STEPS;
                     DL_ERR    <= 1'b0;
                     DL_BUSY   <= 1'b1;
                     dl_state  <= DL_LOAD_CMD ? S_LOAD : S_MOVE;
                  end else begin
                     DL_ERR  <= 1'b1;
                     DL_DONE <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               DELAY_LINE_LOAD[lane_q] <= 1'b1;
               tap_q[lane_q]           <= '0;
               settle_cnt              <= '0;
               dl_state                <= S_SETTLE;
            end
            S_MOVE: begin
               if (steps_rem == '0) begin
                  DL_DONE              <= 1'b1;
                  DL_BUSY              <= 1'b0;
                  DELAY_LINE_DIRECTION <= '0;
                  dl_state             <= S_DONE;
               end else begin
                  DELAY_LINE_MOVE[lane_q] <= 1'b1;
                  // NOTE: of two nonblocking writes to the same bit in one block,
                  // the later one wins, so this clears every other lane's bit.
                  DELAY_LINE_DIRECTION         <= '0;
                  DELAY_LINE_DIRECTION[lane_q] <= dir_q;
                  if (dir_q && tap_q[lane_q] != TAP_MAX) begin
                     tap_q[lane_q] <= tap_q[lane_q] + 1'b1;
                  end else if (!dir_q && tap_q[lane_q] != '0) begin
                     tap_q[lane_q] <= tap_q[lane_q] - 1'b1;
                  end
                  settle_cnt <= '0;
                  dl_state   <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               // The IOD's range flag is judged once the line has settled.
               if (settle_cnt == SETTLE_LAST) begin
                  if (DELAY_LINE_OUT_OF_RANGE[lane_q] || load_q) begin
                     if (DELAY_LINE_OUT_OF_RANGE[lane_q]) begin
                        DL_ERR <= 1'b1;
                     end
                     DL_DONE              <= 1'b1;
                     DL_BUSY              <= 1'b0;
                     DELAY_LINE_DIRECTION <= '0;
                     dl_state             <= S_DONE;
                  end else begin
                     steps_rem <= steps_rem - 1'b1;
                     dl_state  <= S_MOVE;
                  end
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end
            S_DONE: begin
               dl_state <= S_IDLE;
            end
            default: begin
               dl_state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      // NOTE: defaulting the whole vector first keeps this purely combinational.
      TAP_CNT = '0;
      for (int i = 0; i < LANES; i++) begin
         TAP_CNT[i*TAP_W +: TAP_W] = tap_q[i];
      end
   end

endmodule

// File: tb/tb_ddr4_dm_multilane_tx_ctrl.sv
// Self-checking bench: command table, hand-written corner sequences and
// randomised traffic against a cycle-history reference model.
module tb_ddr4_dm_multilane_tx_ctrl;

   localparam int LANES      = 2;
   localparam int PRE_CYC    = 1;
   localparam int POST_CYC   = 1;
   localparam int ODT_HOLD   = 2;
   localparam int SETTLE_CYC = 4;
   localparam int TAP_W      = 8;
   localparam int D          = PRE_CYC + 1;
   localparam int OE_LEN     = D + POST_CYC;
   localparam int HIST       = OE_LEN + ODT_HOLD;
   localparam int MAXC       = 6000;

   logic                   clk;
   logic                   TX_SYNC_RST;
   logic                   WR_EN;
   logic [LANES*8-1:0]     WR_DM_N;
   logic [LANES*8-1:0]     TX_DATA;
   logic [LANES*4-1:0]     OE_DATA;
   logic [LANES-1:0]       ODT_EN;
   logic                   DL_REQ;
   logic [3:0]             DL_LANE;
   logic                   DL_LOAD_CMD;
   logic                   DL_DIR;
   logic [TAP_W-1:0]       DL_STEPS;
   logic                   DL_BUSY;
   logic                   DL_DONE;
   logic                   DL_ERR;
   logic [LANES*TAP_W-1:0] TAP_CNT;
   logic [LANES-1:0]       DELAY_LINE_MOVE;
   logic [LANES-1:0]       DELAY_LINE_DIRECTION;
   logic [LANES-1:0]       DELAY_LINE_LOAD;
   logic [LANES-1:0]       DELAY_LINE_OUT_OF_RANGE;

   ddr4_dm_multilane_tx_ctrl #(
      .LANES(LANES), .PRE_CYC(PRE_CYC), .POST_CYC(POST_CYC),
      .ODT_HOLD(ODT_HOLD), .SETTLE_CYC(SETTLE_CYC), .TAP_W(TAP_W)
   ) dut (
      .FAB_CLK(clk),
      .TX_SYNC_RST(TX_SYNC_RST),
      .WR_EN(WR_EN),
      .WR_DM_N(WR_DM_N),
      .TX_DATA(TX_DATA),
      .OE_DATA(OE_DATA),
      .ODT_EN(ODT_EN),
      .DL_REQ(DL_REQ),
      .DL_LANE(DL_LANE),
      .DL_LOAD_CMD(DL_LOAD_CMD),
      .DL_DIR(DL_DIR),
      .DL_STEPS(DL_STEPS),
      .DL_BUSY(DL_BUSY),
      .DL_DONE(DL_DONE),
      .DL_ERR(DL_ERR),
      .TAP_CNT(TAP_CNT),
      .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
      .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
      .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
      .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Write-path history indexed by cycle number
   bit               wr_log [MAXC];
   logic [15:0]      dm_log [MAXC];
   int               last_rst = 0;

   // Delay-line reference state
   bit  dl_model_en = 1'b1;
   bit  pending     = 1'b0;
   bit  cmd_valid   = 1'b0;
   int  cmd_r       = 0;
   int  cmd_done    = 0;
   int  cmd_lane    = 0;
   bit  cmd_dir     = 1'b0;
   int  exp_moves   = 0;
   int  exp_loads   = 0;
   int  model_tap [LANES];
   bit  model_err   = 1'b0;
   int  move_tgt, move_other, load_tgt, load_other;

   typedef struct {
      int          lane;
      bit          load;
      bit          dir;
      int          steps;
      logic [15:0] exp_tap;
      bit          exp_err;
      int          exp_lat;
   } dl_vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit wr_in(input int lo, input int hi);
      int l = lo;
      if (l < last_rst + 1) l = last_rst + 1;
      for (int t = l; t <= hi; t++) begin
         if (t >= 0 && wr_log[t]) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [15:0] tap_vec();
      logic [15:0] v = '0;
      for (int i = 0; i < LANES; i++) v[i*TAP_W +: TAP_W] = 8'(model_tap[i]);
      return v;
   endfunction

   // Advance one cycle, compare everything the model knows, then set idle inputs.
   task automatic tick();
      bit          oe_e, odt_e, done_e, busy_e;
      logic [15:0] tx_e;
      @(negedge clk);
      cyc++;
      if (cyc >= MAXC - 1) begin
         $display("FAIL cycle_budget at cycle %0d: got %0d expected below %0d", cyc, cyc, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      oe_e  = wr_in(cyc - OE_LEN, cyc - 1);
      odt_e = wr_in(cyc - HIST, cyc - 1);
      tx_e  = (cyc - D > last_rst && wr_log[cyc - D]) ? dm_log[cyc - D] : 16'hFFFF;
      check("oe_data", OE_DATA, {8{oe_e}});
      check("odt_en", ODT_EN, {2{odt_e}});
      check("tx_data", TX_DATA, tx_e);

      for (int i = 0; i < LANES; i++) begin
         if (DELAY_LINE_MOVE[i]) begin
            if (i == cmd_lane) begin
               move_tgt++;
               check("move_dir", DELAY_LINE_DIRECTION[i], cmd_dir);
            end else move_other++;
         end
         if (DELAY_LINE_LOAD[i]) begin
            if (i == cmd_lane) load_tgt++;
            else load_other++;
         end
      end
      if (DELAY_LINE_MOVE != '0 || DELAY_LINE_LOAD != '0)
         check("pulse_excl", $countones({DELAY_LINE_MOVE, DELAY_LINE_LOAD}), 1);

      if (dl_model_en) begin
         done_e = pending && cyc == cmd_done;
         busy_e = pending && cmd_valid && cyc > cmd_r && cyc < cmd_done;
         check("dl_done", DL_DONE, done_e);
         check("dl_busy", DL_BUSY, busy_e);
         if (done_e) begin
            check("dl_moves", move_tgt, exp_moves);
            check("dl_loads", load_tgt, exp_loads);
            check("dl_stray", move_other + load_other, 0);
            check("dl_tap", TAP_CNT, tap_vec());
            check("dl_err", DL_ERR, model_err);
            pending = 1'b0;
         end
      end

      TX_SYNC_RST = 1'b0;
      WR_EN       = 1'b0;
      WR_DM_N     = 16'($urandom);
      wr_log[cyc] = 1'b0;
      DL_REQ      = 1'b0;
   endtask

   task automatic drive_wr(input logic [15:0] dm);
      WR_EN       = 1'b1;
      WR_DM_N     = dm;
      wr_log[cyc] = 1'b1;
      dm_log[cyc] = dm;
   endtask

   task automatic issue_dl(input int lane, input bit load, input bit dir, input int steps);
      int t;
      DL_REQ      = 1'b1;
      DL_LANE     = 4'(lane);
      DL_LOAD_CMD = load;
      DL_DIR      = dir;
      DL_STEPS    = 8'(steps);
      cmd_r = cyc; cmd_lane = lane; cmd_dir = dir; pending = 1'b1;
      move_tgt = 0; move_other = 0; load_tgt = 0; load_other = 0;
      if (lane >= LANES) begin
         cmd_valid = 1'b0; cmd_done = cyc + 1; exp_moves = 0; exp_loads = 0; model_err = 1'b1;
      end else if (load) begin
         cmd_valid = 1'b1; cmd_done = cyc + 2 + SETTLE_CYC; exp_moves = 0; exp_loads = 1;
         model_tap[lane] = 0; model_err = 1'b0;
      end else begin
         cmd_valid = 1'b1; cmd_done = cyc + 2 + steps * (SETTLE_CYC + 1);
         exp_moves = steps; exp_loads = 0; model_err = 1'b0;
         t = dir ? model_tap[lane] + steps : model_tap[lane] - steps;
         model_tap[lane] = (t < 0) ? 0 : (t > 255) ? 255 : t;
      end
   endtask

   task automatic apply_rst();
      TX_SYNC_RST = 1'b1;
      last_rst    = cyc;
      pending     = 1'b0;
      model_err   = 1'b0;
      for (int i = 0; i < LANES; i++) model_tap[i] = 0;
   endtask

   task automatic wait_done(output int lat);
      int r = cyc;
      lat = -1;
      for (int k = 0; k < 200; k++) begin
         tick();
         if (DL_DONE === 1'b1) begin
            lat = cyc - r;
            break;
         end
      end
   endtask

   dl_vec_t tbl [8];

   initial begin
      int lat, t0;
      bit oor_set;
      tbl[0] = '{1,  1'b0, 1'b1, 3, 16'h0300, 1'b0, 17};
      tbl[1] = '{0,  1'b0, 1'b0, 2, 16'h0300, 1'b0, 12};
      tbl[2] = '{0,  1'b0, 1'b1, 0, 16'h0300, 1'b0, 2};
      tbl[3] = '{2,  1'b0, 1'b1, 1, 16'h0300, 1'b1, 1};
      tbl[4] = '{1,  1'b1, 1'b0, 0, 16'h0000, 1'b0, 6};
      tbl[5] = '{0,  1'b0, 1'b1, 4, 16'h0004, 1'b0, 22};
      tbl[6] = '{15, 1'b0, 1'b0, 3, 16'h0004, 1'b1, 1};
      tbl[7] = '{1,  1'b0, 1'b0, 1, 16'h0004, 1'b0, 7};

      for (int i = 0; i < LANES; i++) model_tap[i] = 0;
      TX_SYNC_RST = 1'b1; WR_EN = 1'b0; WR_DM_N = '0;
      DL_REQ = 1'b0; DL_LANE = '0; DL_LOAD_CMD = 1'b0; DL_DIR = 1'b0; DL_STEPS = '0;
      DELAY_LINE_OUT_OF_RANGE = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         apply_rst();
      end
      tick();
      check("rst_tx", TX_DATA, 16'hFFFF);
      check("rst_tap", TAP_CNT, 16'h0000);
      check("rst_flags", {DL_BUSY, DL_DONE, DL_ERR, DELAY_LINE_MOVE, DELAY_LINE_LOAD}, 7'b0);

      // Command table
      foreach (tbl[n]) begin
         tick();
         issue_dl(tbl[n].lane, tbl[n].load, tbl[n].dir, tbl[n].steps);
         wait_done(lat);
         check("tbl_lat", lat, tbl[n].exp_lat);
         check("tbl_tap", TAP_CNT, tbl[n].exp_tap);
         check("tbl_err", DL_ERR, tbl[n].exp_err);
         tick();
      end

      // Single burst: data at t+2, OE t+1..t+3, ODT t+1..t+5
      tick();
      t0 = cyc;
      drive_wr(16'h3CA5);
      for (int k = 1; k <= 8; k++) begin
         tick();
         check("b1_tx", TX_DATA, (k == 2) ? 16'h3CA5 : 16'hFFFF);
         check("b1_oe", OE_DATA, (k <= 3) ? 8'hFF : 8'h00);
         check("b1_odt", ODT_EN, (k <= 5) ? 2'b11 : 2'b00);
      end

      // Bursts at t and t+2 merge: OE t+1..t+5, ODT through t+7
      tick();
      t0 = cyc;
      drive_wr(16'h1122);
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 2) drive_wr(16'h3344);
         check("b2_tx", TX_DATA, (k == 2) ? 16'h1122 : (k == 4) ? 16'h3344 : 16'hFFFF);
         check("b2_oe", OE_DATA, (k <= 5) ? 8'hFF : 8'h00);
         check("b2_odt", ODT_EN, (k <= 7) ? 2'b11 : 2'b00);
      end

      // Out-of-range after the second move
      tick();
      apply_rst();
      tick();
      dl_model_en = 1'b0;
      t0 = cyc;
      DL_REQ = 1'b1; DL_LANE = 4'd0; DL_LOAD_CMD = 1'b0; DL_DIR = 1'b1; DL_STEPS = 8'd5;
      cmd_lane = 0; cmd_dir = 1'b1;
      move_tgt = 0; move_other = 0; load_tgt = 0; load_other = 0;
      oor_set = 1'b0; lat = -1;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (move_tgt == 2 && !oor_set) begin
            DELAY_LINE_OUT_OF_RANGE = 2'b01;
            oor_set = 1'b1;
         end
         if (DL_DONE === 1'b1) begin
            lat = cyc - t0;
            break;
         end
      end
      check("oor_lat", lat, 11);
      check("oor_moves", move_tgt, 2);
      check("oor_err", DL_ERR, 1'b1);
      check("oor_tap", TAP_CNT, 16'h0002);
      DELAY_LINE_OUT_OF_RANGE = '0;
      model_tap[0] = 2; model_tap[1] = 0;
      tick();
      dl_model_en = 1'b1;

      // Reset mid-burst and mid-step
      tick();
      drive_wr(16'h1234);
      issue_dl(1, 1'b0, 1'b1, 3);
      tick();
      tick();
      check("pre_rst_tap", TAP_CNT[15:8], 8'd3 - 8'd2);
      apply_rst();
      tick();
      check("mid_rst_oe", OE_DATA, 8'h00);
      check("mid_rst_odt", ODT_EN, 2'b00);
      check("mid_rst_tx", TX_DATA, 16'hFFFF);
      check("mid_rst_tap", TAP_CNT, 16'h0000);
      check("mid_rst_busy", DL_BUSY, 1'b0);
      check("mid_rst_done", DL_DONE, 1'b0);
      for (int k = 0; k < 25; k++) tick();

      // Randomised concurrent traffic
      for (int k = 0; k < 1500; k++) begin
         tick();
         if ($urandom_range(2) == 0) drive_wr(16'($urandom));
         if (!pending && cyc > cmd_done && $urandom_range(3) == 0)
            issue_dl($urandom_range(LANES), $urandom_range(3) == 0, 1'($urandom),
                     $urandom_range(6));
      end
      for (int k = 0; k < 60; k++) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
